// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory req/gnt/rvalid channel, decode-side
// inst_valid/inst_ready channel and PC redirect input.
interface ifu_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues single outstanding word reads and
// hands one instruction at a time to decode; halts on ebreak or misaligned redirect.
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// REQ   | imem_req high at pc, waiting for gnt
// WAIT  | request granted, waiting for rvalid (kill drops the data)
// HOLD  | instruction presented to decode until inst_ready or redirect
// HALT  | fetch stopped; only rst leaves
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] EBREAK   = 32'h0010_0073
) (
    input  logic clk,
    input  logic rst,
    ifu_fetch_if.master bus,
    output logic halted,
    output logic fetch_err
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] HOLD = 3'd3;
    localparam logic [2:0] HALT = 3'd4;

    logic [2:0]  state;
    logic [31:0] pc;
    logic        kill;
    logic        inst_valid_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        misaligned;
    logic        consume_ebreak;

    assign misaligned     = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
    assign consume_ebreak = inst_valid_q && bus.inst_ready && (inst_q == EBREAK);

    assign bus.imem_req   = (state == REQ);
    assign bus.imem_addr  = {pc[31:2], 2'b00};
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            kill         <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            halted       <= 1'b0;
            fetch_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (misaligned) begin
                        fetch_err <= 1'b1;
                        halted    <= 1'b1;
                        state     <= HALT;
                    end else begin
                        if (bus.redirect) pc <= bus.redirect_pc;
                        if (bus.imem_gnt) begin
                            // a redirect alongside gnt means the granted word is stale
                            kill  <= bus.redirect;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (misaligned) begin
                        fetch_err <= 1'b1;
                        halted    <= 1'b1;
                        state     <= HALT;
                    end else if (bus.imem_rvalid) begin
                        if (kill || bus.redirect) begin
                            if (bus.redirect) pc <= bus.redirect_pc;
                            kill  <= 1'b0;
                            state <= REQ;
                        end else begin
                            inst_q       <= bus.imem_rdata;
                            inst_pc_q    <= pc;
                            inst_valid_q <= 1'b1;
                            state        <= HOLD;
                        end
                    end else if (bus.redirect) begin
                        pc   <= bus.redirect_pc;
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    // ebreak wins over any redirect resolved in the same cycle
                    if (consume_ebreak) begin
                        inst_valid_q <= 1'b0;
                        halted       <= 1'b1;
                        state        <= HALT;
                    end else if (misaligned) begin
                        inst_valid_q <= 1'b0;
                        fetch_err    <= 1'b1;
                        halted       <= 1'b1;
                        state        <= HALT;
                    end else if (bus.inst_ready || bus.redirect) begin
                        inst_valid_q <= 1'b0;
                        pc           <= bus.redirect ? bus.redirect_pc : pc + 32'd4;
                        state        <= REQ;
                    end
                end
                HALT: inst_valid_q <= 1'b0;
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: cycle-by-cycle vector table from reset plus
// hand-written sequences for PC wrap, misaligned redirect and reset mid-WAIT.
module tb_ifu_fetch;
    logic clk;
    logic rst;
    logic halted;
    logic fetch_err;

    ifu_fetch_if bus ();

    ifu_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .halted    (halted),
        .fetch_err (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        e_halt;
        logic        e_err;
    } vec_t;

    vec_t vt[$];
    int   n_pass  = 0;
    int   n_total = 0;

    localparam logic [31:0] A0 = 32'h8000_0000;

    task automatic add(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                       input logic ready, input logic redir, input logic [31:0] rpc,
                       input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                       input logic [31:0] e_inst, input logic [31:0] e_ipc,
                       input logic e_halt, input logic e_err);
        vec_t v;
        v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata; v.ready = ready;
        v.redir = redir; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr;
        v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc;
        v.e_halt = e_halt; v.e_err = e_err;
        vt.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                         input logic ready, input logic redir, input logic [31:0] rpc);
        bus.imem_gnt    = gnt;
        bus.imem_rvalid = rvalid;
        bus.imem_rdata  = rdata;
        bus.inst_ready  = ready;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
    endtask

    task automatic cyc(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                       input logic ready, input logic redir, input logic [31:0] rpc);
        drive(gnt, rvalid, rdata, ready, redir, rpc);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " imem_req"},   {31'h0, bus.imem_req},   32'h0);
        check({tag, " inst_valid"}, {31'h0, bus.inst_valid}, 32'h0);
        check({tag, " inst"},       bus.inst,                32'h0);
        check({tag, " inst_pc"},    bus.inst_pc,             32'h0);
        check({tag, " halted"},     {31'h0, halted},         32'h0);
        check({tag, " fetch_err"},  {31'h0, fetch_err},      32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // main table: one record per cycle, expectations are the outputs seen before that edge
        add(0,0,0,0,0,0,                          0,A0,0,0,0,0,0);
        add(1,0,0,0,0,0,                          1,A0,0,0,0,0,0);
        add(0,1,32'h1111_1113,0,0,0,              0,A0,0,0,0,0,0);
        add(0,0,0,1,0,0,                          0,A0,1,32'h1111_1113,A0,0,0);
        add(1,0,0,0,0,0,                          1,32'h8000_0004,0,0,0,0,0);
        add(0,1,32'h2222_2223,0,0,0,              0,A0,0,0,0,0,0);
        add(0,0,0,1,0,0,                          0,A0,1,32'h2222_2223,32'h8000_0004,0,0);
        for (int i = 0; i < 5; i++)
            add(0,1,32'hdead_beef,0,0,0,          1,32'h8000_0008,0,0,0,0,0);
        add(1,0,0,0,0,0,                          1,32'h8000_0008,0,0,0,0,0);
        add(0,0,0,0,0,0,                          0,A0,0,0,0,0,0);
        add(0,1,32'h3333_3333,0,0,0,              0,A0,0,0,0,0,0);
        for (int i = 0; i < 4; i++)
            add(0,0,0,0,0,0,                      0,A0,1,32'h3333_3333,32'h8000_0008,0,0);
        add(0,0,0,1,0,0,                          0,A0,1,32'h3333_3333,32'h8000_0008,0,0);
        add(1,0,0,0,0,0,                          1,32'h8000_000c,0,0,0,0,0);
        add(0,0,0,0,1,32'h8000_0100,              0,A0,0,0,0,0,0);
        add(0,1,32'h4444_4444,0,0,0,              0,A0,0,0,0,0,0);
        add(1,0,0,0,0,0,                          1,32'h8000_0100,0,0,0,0,0);
        add(0,1,32'h5a5a_5a5a,0,1,32'h8000_0200,  0,A0,0,0,0,0,0);
        add(0,0,0,0,1,32'h8000_0300,              1,32'h8000_0200,0,0,0,0,0);
        add(1,0,0,0,1,32'h8000_0400,              1,32'h8000_0300,0,0,0,0,0);
        add(0,1,32'h5555_5555,0,0,0,              0,A0,0,0,0,0,0);
        add(1,0,0,0,0,0,                          1,32'h8000_0400,0,0,0,0,0);
        add(0,1,32'h6666_6666,0,0,0,              0,A0,0,0,0,0,0);
        add(0,0,0,0,1,32'h8000_0500,              0,A0,1,32'h6666_6666,32'h8000_0400,0,0);
        add(1,0,0,0,0,0,                          1,32'h8000_0500,0,0,0,0,0);
        add(0,1,32'h7777_7777,0,0,0,              0,A0,0,0,0,0,0);
        add(0,0,0,1,1,32'h8000_0600,              0,A0,1,32'h7777_7777,32'h8000_0500,0,0);
        add(1,0,0,0,0,0,                          1,32'h8000_0600,0,0,0,0,0);
        add(0,1,32'h0010_0073,0,0,0,              0,A0,0,0,0,0,0);
        add(0,0,0,1,1,32'h8000_0700,              0,A0,1,32'h0010_0073,32'h8000_0600,0,0);
        for (int i = 0; i < 3; i++)
            add(1,1,32'h1234_5678,1,1,32'h8000_0800, 0,A0,0,0,0,1,0);

        do_reset();
        check_reset_state("reset");
        foreach (vt[i]) begin
            drive(vt[i].gnt, vt[i].rvalid, vt[i].rdata, vt[i].ready, vt[i].redir, vt[i].rpc);
            check($sformatf("v%0d imem_req", i), {31'h0, bus.imem_req}, {31'h0, vt[i].e_req});
            if (vt[i].e_req)
                check($sformatf("v%0d imem_addr", i), bus.imem_addr, vt[i].e_addr);
            check($sformatf("v%0d inst_valid", i), {31'h0, bus.inst_valid}, {31'h0, vt[i].e_iv});
            if (vt[i].e_iv) begin
                check($sformatf("v%0d inst", i), bus.inst, vt[i].e_inst);
                check($sformatf("v%0d inst_pc", i), bus.inst_pc, vt[i].e_ipc);
            end
            check($sformatf("v%0d halted", i), {31'h0, halted}, {31'h0, vt[i].e_halt});
            check($sformatf("v%0d fetch_err", i), {31'h0, fetch_err}, {31'h0, vt[i].e_err});
            @(posedge clk);
            @(negedge clk);
        end

        // pc+4 wraps from the top of the address space
        do_reset();
        cyc(0,0,0,0,0,0);
        cyc(0,0,0,0,1,32'hffff_fffc);
        check("wrap addr", bus.imem_addr, 32'hffff_fffc);
        cyc(1,0,0,0,0,0);
        cyc(0,1,32'h8888_8888,0,0,0);
        check("wrap inst_pc", bus.inst_pc, 32'hffff_fffc);
        cyc(0,0,0,1,0,0);
        check("wrap req", {31'h0, bus.imem_req}, 32'h1);
        check("wrap next addr", bus.imem_addr, 32'h0000_0000);

        // misaligned redirect halts with error, pc unchanged, then stays dead
        cyc(0,0,0,0,1,32'h8000_0102);
        check("mis fetch_err", {31'h0, fetch_err}, 32'h1);
        check("mis halted", {31'h0, halted}, 32'h1);
        check("mis req", {31'h0, bus.imem_req}, 32'h0);
        cyc(1,1,32'h0,1,1,32'h8000_0000);
        cyc(1,1,32'h0,1,0,32'h0);
        check("mis stay req", {31'h0, bus.imem_req}, 32'h0);
        check("mis stay iv", {31'h0, bus.inst_valid}, 32'h0);
        check("mis stay halted", {31'h0, halted}, 32'h1);

        // reset while a request is outstanding; the stale rvalid must be ignored
        do_reset();
        cyc(0,0,0,0,0,0);
        cyc(1,0,0,0,0,0);
        rst = 1'b1;
        drive(0,0,32'h0,0,0,32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("rst mid-wait");
        cyc(0,1,32'h9999_9999,0,0,0);
        check("stale req", {31'h0, bus.imem_req}, 32'h1);
        check("stale addr", bus.imem_addr, A0);
        cyc(0,1,32'h9999_9999,0,0,0);
        check("stale iv", {31'h0, bus.inst_valid}, 32'h0);
        check("stale addr held", bus.imem_addr, A0);
        cyc(1,0,0,0,0,0);
        cyc(0,1,32'haaaa_aaaa,0,0,0);
        check("post-rst iv", {31'h0, bus.inst_valid}, 32'h1);
        check("post-rst inst", bus.inst, 32'haaaa_aaaa);
        check("post-rst inst_pc", bus.inst_pc, A0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
